// File: rtl/div_pkg.sv
// Shared constants for the sequential divider: default operand width and FSM state encodings.
package div_pkg;
  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step, purely combinational.
// Shift in the next dividend bit, subtract the divisor if it fits, report the quotient bit.
import div_pkg::*;

module div_step #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, next_bit};
  assign diff    = shifted - {1'b0, divisor};
  // rem_in < divisor keeps shifted < 2*divisor, so diff's top bit is exactly the borrow.
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned divider: start -> done after WIDTH+2 cycles (next cycle for b=0).
// Start is ignored while busy; results hold until the next completed division.
import div_pkg::*;

module div_seq #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;

  assign a_neg = signed_mode & a[WIDTH-1];
  assign b_neg = signed_mode & b[WIDTH-1];
  // Magnitude of the most-negative value wraps to itself, which is correct as unsigned.
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // The dividend register doubles as the quotient: bits leave at the top, quotient bits enter at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem),
    .next_bit (acc[WIDTH-1]),
    .divisor  (dvs),
    .rem_out  (rem_nxt),
    .q_bit    (q_bit)
  );

  assign busy = (state == CALC) || (state == SIGN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      rem         <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            if (b == '0) begin
              quotient    <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              acc   <= a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              cnt   <= '0;
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= {acc[WIDTH-2:0], q_bit};
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= SIGN;
        end
        SIGN: begin
          quotient    <= q_neg ? -acc : acc;
          remainder   <= r_neg ? -rem : rem;
          div_by_zero <= 1'b0;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: expected results queued at issue, popped by a done-driven monitor.
module tb_div_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation, including its cycle.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(mon_e.q));
        check("remainder", 64'(remainder), 64'(mon_e.r));
        check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic go_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives start for one cycle from the current (post-edge) time; returns the issue cycle.
  task automatic issue(input logic sm, input logic [31:0] va, input logic [31:0] vb,
                       input bit push, input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, output int n);
    exp_t e;
    start       = 1'b1;
    signed_mode = sm;
    a           = va;
    b           = vb;
    n           = cyc;
    if (push) begin
      e.q   = eq;
      e.r   = er;
      e.dbz = edbz;
      e.cyc = n + ((vb == 32'd0) ? 1 : 34);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_0001;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 100/7 unsigned with busy window N+1..N+33
    issue(1'b0, 32'd100, 32'd7, 1, 32'd14, 32'd2, 1'b0, n);
    bad = 0;
    for (int c = n + 1; c <= n + 36; c++) begin
      @(negedge clk);
      if (busy !== ((cyc >= n + 1) && (cyc <= n + 33))) bad++;
    end
    check("busy_window", 64'(bad), 64'd0);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("hold_quotient", 64'(quotient), 64'd14);

    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, n);
    wait_idle();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 32'd1, 1'b0, n);
    wait_idle();
    issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1, 32'd14, 32'hFFFF_FFFE, 1'b0, n);
    wait_idle();
    issue(1'b0, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1, n);
    wait_idle();
    issue(1'b1, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1, n);
    wait_idle();
    issue(1'b1, 32'h8000_0000, 32'd0, 1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, n);
    wait_idle();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'd0, 1'b0, n);
    wait_idle();
    issue(1'b0, 32'hFFFF_FFFF, 32'd2, 1, 32'h7FFF_FFFF, 32'd1, 1'b0, n);
    wait_idle();
    issue(1'b0, 32'd7, 32'd100, 1, 32'd0, 32'd7, 1'b0, n);
    wait_idle();

    // Reset mid-operation: no done, outputs cleared, then a fresh division works
    issue(1'b0, 32'd100, 32'd7, 0, 32'd0, 32'd0, 1'b0, n);
    go_cycle(n + 10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_quotient", 64'(quotient), 64'd0);
    check("midrst_remainder", 64'(remainder), 64'd0);
    check("midrst_dbz", 64'(div_by_zero), 64'd0);
    go_cycle(n + 40);
    issue(1'b0, 32'd9, 32'd3, 1, 32'd3, 32'd0, 1'b0, n);
    wait_idle();

    // Start while busy is ignored; start during DONE is accepted back-to-back
    issue(1'b0, 32'd100, 32'd7, 1, 32'd14, 32'd2, 1'b0, n);
    go_cycle(n + 5);
    begin
      int n2;
      issue(1'b0, 32'd50, 32'd5, 0, 32'd0, 32'd0, 1'b0, n2);
    end
    go_cycle(n + 34);
    check("b2b_done_seen", 64'(done), 64'd1);
    issue(1'b0, 32'd9, 32'd3, 1, 32'd3, 32'd0, 1'b0, n);
    wait_idle();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only when the block is idle or done.
REQ-005 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a, input, WIDTH bits: dividend; sampled with start.
REQ-007 SHALL have port b, input, WIDTH bits: divisor; sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle pulse when results become valid.
REQ-010 SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-011 SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-012 SHALL have port div_by_zero, output, 1 bit: high with results when the captured b was 0.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, SIGN, DONE.
REQ-014 SHALL, in IDLE or DONE with start=1, register a, b and signed_mode, take operand magnitudes and record result signs: IDLE/DONE->CALC, or ->DONE directly when b=0.
REQ-015 SHALL, in CALC, perform one restoring radix-2 step per cycle (shift partial remainder left by one, bring in the next dividend MSB, subtract b when remainder>=b and set that quotient bit) for exactly WIDTH cycles, counted by a ceil(log2(WIDTH+1))-bit counter.
REQ-016 SHALL, in SIGN, negate the quotient when the operand signs differ and negate the remainder when the dividend was negative (signed mode only), then go to DONE.
REQ-017 SHALL have latency as follows: start high in cycle N gives done=1 in cycle N+WIDTH+2; for b=0 it gives done=1 in cycle N+1.
REQ-018 SHALL assert busy in CALC and SIGN only, and done in DONE only; DONE lasts one cycle, then goes to IDLE unless start is high.
REQ-019 SHALL ignore start while busy=1; the operation in flight and its operands SHALL be unaffected.
REQ-020 SHALL hold quotient, remainder and div_by_zero stable from done until the cycle after the next accepted start; they SHALL be updated only on entry to DONE.
REQ-021 SHALL, when b=0, produce quotient = all ones, remainder = a unchanged and div_by_zero=1, in both modes.
REQ-022 SHALL, in signed mode, produce quotient = the most-negative value and remainder = 0 for a = most-negative value and b = -1, with div_by_zero=0.
REQ-023 SHALL truncate signed results toward zero; a nonzero remainder SHALL take the dividend's sign.
REQ-024 SHALL perform all internal arithmetic at WIDTH+1 bits so that the compare/subtract cannot overflow.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, go to IDLE and clear busy, done, quotient, remainder, div_by_zero and the step counter to 0.
REQ-026 SHALL, when reset is asserted mid-operation, abandon the operation with no done pulse; rst SHALL take priority over start in the same cycle.

Structure
REQ-027 SHALL keep the FSM state enum and the WIDTH default constant in shared package div_pkg.
REQ-028 SHALL implement one restoring step as combinational sub-module div_step (inputs: partial remainder, next bit, divisor; outputs: new remainder, quotient bit).

Verification
REQ-029 SHALL cover: WIDTH=32, unsigned, a=100, b=7, start in cycle N -> quotient=14, remainder=2, done only in cycle N+34, busy high in cycles N+1..N+33.
REQ-030 SHALL cover: signed a=-7, b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); and a=7, b=-2 -> quotient=-3, remainder=1.
REQ-031 SHALL cover: a=5, b=0 in either mode -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done in cycle N+1.
REQ-032 SHALL cover: signed a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-033 SHALL cover: start 100/7, rst pulsed in cycle N+10 -> busy=0 and all outputs 0 from N+11, no done pulse; a following start 9/3 -> quotient=3, remainder=0.
REQ-034 SHALL cover: start 100/7, then start 50/5 at cycle N+5 while busy -> the second start is ignored and results are 14/2; back-to-back start during DONE is accepted.
